// File: rtl/regfile_write_arbiter.sv
// regfile_write_arbiter
// Two CPU cores share one register-file write port. Each core hands its write
// to a private 1-entry holding buffer through a valid/ready handshake. A
// round-robin arbiter drains one buffer per cycle into a registered
// regwrite/wa/wd stage that drives the register file write port directly.
// Writes to register 0 are drained like any other entry but never assert
// regwrite, so register 0 stays untouched.

module regfile_write_arbiter #(
  parameter int WIDTH   = 8,
  parameter int REGBITS = 5
) (
  input  logic               clk,
  input  logic               rst_n,
  // core 0 write request
  input  logic               c0_wr_valid,
  output logic               c0_wr_ready,
  input  logic [REGBITS-1:0] c0_wr_addr,
  input  logic [WIDTH-1:0]   c0_wr_data,
  // core 1 write request
  input  logic               c1_wr_valid,
  output logic               c1_wr_ready,
  input  logic [REGBITS-1:0] c1_wr_addr,
  input  logic [WIDTH-1:0]   c1_wr_data,
  // register file write port
  output logic               regwrite,
  output logic [REGBITS-1:0] wa,
  output logic [WIDTH-1:0]   wd,
  // status
  output logic [1:0]         pending,
  output logic               collision
);

  localparam int NCORES = 2;

  // Round-robin pointer: names the core that wins when both buffers hold an entry.
  typedef enum logic {
    RR_CORE0 = 1'b0,
    RR_CORE1 = 1'b1
  } rr_state_t;

  rr_state_t r_rr_ptr;
  rr_state_t w_rr_ptr_next;

  // Per-core request inputs gathered into arrays so the buffer logic can be
  // generated once per core.
  logic [NCORES-1:0]  w_wr_valid;
  logic [NCORES-1:0]  w_wr_ready;
  logic [NCORES-1:0]  w_accept;
  logic [REGBITS-1:0] w_wr_addr [NCORES];
  logic [WIDTH-1:0]   w_wr_data [NCORES];

  // Holding buffer contents, as seen by the arbiter.
  logic [NCORES-1:0]  w_buf_vld;
  logic [REGBITS-1:0] w_buf_addr [NCORES];
  logic [WIDTH-1:0]   w_buf_data [NCORES];

  // Arbitration results.
  logic [NCORES-1:0]  w_grant;
  logic               w_grant_any;
  logic [REGBITS-1:0] w_gnt_addr;
  logic [WIDTH-1:0]   w_gnt_data;
  logic               w_same_addr;

  // Registered write-port stage.
  logic               r_regwrite;
  logic [REGBITS-1:0] r_wa;
  logic [WIDTH-1:0]   r_wd;
  logic               r_collision;

  assign w_wr_valid   = {c1_wr_valid, c0_wr_valid};
  assign w_wr_addr[0] = c0_wr_addr;
  assign w_wr_addr[1] = c1_wr_addr;
  assign w_wr_data[0] = c0_wr_data;
  assign w_wr_data[1] = c1_wr_data;

  // ---------------------------------------------------------------------------
  // Per-core handshake and holding buffer.
  // Ready depends only on registered occupancy and this cycle's grant, never on
  // the core's own valid, so there is no combinational valid->ready path. A
  // buffer being drained this cycle can take a new entry at the same edge,
  // which gives one write per cycle per core when the other core is idle.
  // ---------------------------------------------------------------------------
  genvar gi;
  generate
    for (gi = 0; gi < NCORES; gi++) begin : g_core
      logic               r_vld;
      logic [REGBITS-1:0] r_addr;
      logic [WIDTH-1:0]   r_data;

      assign w_wr_ready[gi] = !r_vld | w_grant[gi];
      assign w_accept[gi]   = w_wr_valid[gi] & w_wr_ready[gi];

      assign w_buf_vld[gi]  = r_vld;
      assign w_buf_addr[gi] = r_addr;
      assign w_buf_data[gi] = r_data;

      // Load on accept (replacing an entry drained this cycle); otherwise empty on grant.
      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
          r_vld  <= 1'b0;
          r_addr <= '0;
          r_data <= '0;
        end else if (w_accept[gi]) begin
          r_vld  <= 1'b1;
          r_addr <= w_wr_addr[gi];
          r_data <= w_wr_data[gi];
        end else if (w_grant[gi]) begin
          r_vld  <= 1'b0;
        end
      end
    end
  endgenerate

  // ---------------------------------------------------------------------------
  // Arbitration: a lone occupied buffer always wins; when both are occupied the
  // pointer decides. The pointer then moves to the other core, so a waiting
  // entry is never passed over more than once.
  // ---------------------------------------------------------------------------

  // Grant selection from buffer occupancy and the round-robin pointer.
  always_comb begin
    w_grant = w_buf_vld;
    if (w_buf_vld == 2'b11) begin
      w_grant = (r_rr_ptr == RR_CORE0) ? 2'b01 : 2'b10;
    end
  end

  // Next pointer: favour the core that was not just served; hold when idle.
  always_comb begin
    w_rr_ptr_next = r_rr_ptr;
    if (w_grant[0]) begin
      w_rr_ptr_next = RR_CORE1;
    end else if (w_grant[1]) begin
      w_rr_ptr_next = RR_CORE0;
    end
  end

  // Pointer register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_rr_ptr <= RR_CORE0;
    end else begin
      r_rr_ptr <= w_rr_ptr_next;
    end
  end

  assign w_grant_any = |w_grant;
  assign w_gnt_addr  = w_grant[1] ? w_buf_addr[1] : w_buf_addr[0];
  assign w_gnt_data  = w_grant[1] ? w_buf_data[1] : w_buf_data[0];

  // Both cores targeting the same real register: they are issued on
  // consecutive cycles in round-robin order, so the later one ends up in the
  // register file. Flagged once, alongside the first of the pair.
  assign w_same_addr = (w_buf_vld == 2'b11)
                     && (w_buf_addr[0] == w_buf_addr[1])
                     && (w_buf_addr[0] != '0);

  // ---------------------------------------------------------------------------
  // Registered write port. wa/wd only change on a grant, so they are only ever
  // loaded from a buffer that was written (or the reset value).
  // ---------------------------------------------------------------------------

  // Write-port stage: enable suppressed for register 0, address/data hold when idle.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_regwrite  <= 1'b0;
      r_wa        <= '0;
      r_wd        <= '0;
      r_collision <= 1'b0;
    end else begin
      r_regwrite  <= w_grant_any && (w_gnt_addr != '0);
      r_collision <= w_same_addr;
      if (w_grant_any) begin
        r_wa <= w_gnt_addr;
        r_wd <= w_gnt_data;
      end
    end
  end

  assign c0_wr_ready = w_wr_ready[0];
  assign c1_wr_ready = w_wr_ready[1];
  assign regwrite    = r_regwrite;
  assign wa          = r_wa;
  assign wd          = r_wd;
  assign pending     = w_buf_vld;
  assign collision   = r_collision;

endmodule
